paddle_ctrl: RTL

Per-player paddle motion controller between a keypad scanner and the VGA renderer. Consumes the raw 4-bit keycode from the scanner and debounces it. Runs a per-frame motion FSM and outputs the paddle's top Y coordinate plus a one-shot serve request. One instance is used per player, clocked on the 25 MHz pixel clock domain.

---
 rtl/pong_pkg.sv | 44 ++++
 rtl/key_debounce.sv | 47 ++++
 rtl/paddle_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared keycodes, screen geometry, paddle FSM types and the Y clamp helper.
// Optional build macro PADDLE_CTRL_ACCEL_EN adds the MOVE_FAST state.
package pong_pkg;

    localparam logic [3:0] KEY_NONE  = 4'h0;
    localparam logic [3:0] KEY_UP    = 4'h2;
    localparam logic [3:0] KEY_DOWN  = 4'h8;
    localparam logic [3:0] KEY_SERVE = 4'h5;

    localparam int SCREEN_H = 480;

`ifdef PADDLE_CTRL_ACCEL_EN
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_SLOW = 2'd1,
        MOVE_FAST = 2'd2
    } paddle_state_t;
`else
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_SLOW = 2'd1
    } paddle_state_t;
`endif

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Saturate a signed candidate position into 0..y_max so it can never wrap.
    function automatic logic [9:0] clamp_y(input logic signed [10:0] v,
                                           input logic [9:0] y_max);
        logic [9:0] r;
        if (v < 11'sd0) begin
            r = 10'd0;
        end else if (v > $signed({1'b0, y_max})) begin
            r = y_max;
        end else begin
            r = v[9:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Keycode debouncer: a keycode must be sampled unchanged DEBOUNCE_CYC+1 times
// before it is accepted; key_chg flags the edge on which key_db takes a new value.
module key_debounce
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keycode,
    output logic [3:0] key_db,
    output logic       key_chg,
    output logic [3:0] key_new
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [3:0]       cand_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       key_db_r;
    logic             load_s;

    assign load_s  = (keycode == cand_r) && (cnt_r == CNT_MAX);
    assign key_chg = load_s && (cand_r != key_db_r);
    assign key_new = cand_r;
    assign key_db  = key_db_r;

    // Candidate tracking, stability counter and accepted-key register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_r   <= KEY_NONE;
            cnt_r    <= {CNT_W{1'b0}};
            key_db_r <= KEY_NONE;
        end else begin
            cand_r <= keycode;
            if (keycode != cand_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (load_s) begin
                key_db_r <= cand_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Per-player paddle motion controller: debounced keypad in, paddle top Y and serve request out.
// Build macro PADDLE_CTRL_ACCEL_EN enables double-speed motion after a long hold.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int PADDLE_H     = 64,
    parameter int Y_INIT       = 208,
    parameter int STEP         = 4,
    parameter int DEBOUNCE_CYC = 8
`ifdef PADDLE_CTRL_ACCEL_EN
   ,parameter int ACCEL_FRAMES = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keycode,
    input  logic       frame_tick,
    input  logic       en,
    output logic [9:0] paddle_y,
    output logic       moving_up,
    output logic       moving_down,
    output logic       serve_pulse,
    output logic [3:0] key_db
);

    localparam logic [9:0]        Y_MAX   = 10'(SCREEN_H - PADDLE_H);
    localparam logic [9:0]        Y_RST   = 10'(Y_INIT);
    localparam logic signed [10:0] STEP_S  = 11'(STEP);
`ifdef PADDLE_CTRL_ACCEL_EN
    localparam logic signed [10:0] STEP2_S = 11'(2 * STEP);
    localparam int                 HOLD_W  = $clog2(ACCEL_FRAMES) + 1;
    // hold_r is about to become ACCEL_FRAMES-1 when it currently holds this value.
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(ACCEL_FRAMES - 2);
    logic [HOLD_W-1:0] hold_r;
`endif

    logic [3:0]           key_db_s;
    logic                 key_chg_s;
    logic [3:0]           key_new_s;
    logic                 serve_pulse_r;
    paddle_state_t        state_r;
    dir_t                 dir_r;
    logic [9:0]           paddle_y_r;
    logic                 moving_up_r;
    logic                 moving_down_r;
    logic                 req_valid_s;
    dir_t                 req_dir_s;
    logic signed [10:0]   delta_s;
    logic signed [10:0]   y_ext_s;
    logic signed [10:0]   y_sum_s;
    logic [9:0]           y_next_s;

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .keycode (keycode),
        .key_db  (key_db_s),
        .key_chg (key_chg_s),
        .key_new (key_new_s)
    );

    assign req_valid_s = (key_db_s == KEY_UP) || (key_db_s == KEY_DOWN);
    assign req_dir_s   = (key_db_s == KEY_UP) ? DIR_UP : DIR_DOWN;

    // Candidate position for this frame, clamped to the visible range.
    always_comb begin
        delta_s = STEP_S;
`ifdef PADDLE_CTRL_ACCEL_EN
        if ((state_r == MOVE_FAST) && (req_dir_s == dir_r)) begin
            delta_s = STEP2_S;
        end else begin
            delta_s = STEP_S;
        end
`endif
        y_ext_s = $signed({1'b0, paddle_y_r});
        if (req_dir_s == DIR_UP) begin
            y_sum_s = y_ext_s - delta_s;
        end else begin
            y_sum_s = y_ext_s + delta_s;
        end
        y_next_s = clamp_y(y_sum_s, Y_MAX);
    end

    // Serve request fires on the edge key_db switches to the serve key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            serve_pulse_r <= 1'b0;
        end else begin
            serve_pulse_r <= key_chg_s && (key_new_s == KEY_SERVE);
        end
    end

    // Per-frame motion FSM with position and direction flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            dir_r         <= DIR_UP;
            paddle_y_r    <= Y_RST;
            moving_up_r   <= 1'b0;
            moving_down_r <= 1'b0;
`ifdef PADDLE_CTRL_ACCEL_EN
            hold_r        <= {HOLD_W{1'b0}};
`endif
        end else if (frame_tick && en) begin
            if (!req_valid_s) begin
                state_r       <= IDLE;
                moving_up_r   <= 1'b0;
                moving_down_r <= 1'b0;
`ifdef PADDLE_CTRL_ACCEL_EN
                hold_r        <= {HOLD_W{1'b0}};
`endif
            end else begin
                paddle_y_r    <= y_next_s;
                dir_r         <= req_dir_s;
                moving_up_r   <= (req_dir_s == DIR_UP);
                moving_down_r <= (req_dir_s == DIR_DOWN);
                if ((state_r == IDLE) || (req_dir_s != dir_r)) begin
                    state_r <= MOVE_SLOW;
`ifdef PADDLE_CTRL_ACCEL_EN
                    hold_r  <= {HOLD_W{1'b0}};
`endif
                end else begin
                    case (state_r)
                        MOVE_SLOW: begin
`ifdef PADDLE_CTRL_ACCEL_EN
                            hold_r <= hold_r + HOLD_W'(1);
                            if (hold_r == HOLD_LAST) begin
                                state_r <= MOVE_FAST;
                            end else begin
                                state_r <= MOVE_SLOW;
                            end
`else
                            state_r <= MOVE_SLOW;
`endif
                        end
`ifdef PADDLE_CTRL_ACCEL_EN
                        MOVE_FAST: state_r <= MOVE_FAST;
`endif
                        default:   state_r <= IDLE;
                    endcase
                end
            end
        end else begin
            state_r <= state_r;
        end
    end

    assign paddle_y    = paddle_y_r;
    assign moving_up   = moving_up_r;
    assign moving_down = moving_down_r;
    assign serve_pulse = serve_pulse_r;
    assign key_db      = key_db_s;

endmodule
